branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the RV32IM pipeline: looks up the fetch PC in the IF stage and returns a taken/not-taken prediction plus target. It is trained in the EX stage by the resolved branch condition (the `out` of the branch comparison logic) and the computed target. It raises a single-cycle mispredict/redirect toward the PC unit and the IF/ID and ID/EX flush logic. Tables are 2-bit saturating counters (BHT) and a tagged branch target buffer (BTB), both direct-mapped.

## Interface
- `ENTRIES`, 64: BHT/BTB depth; power of 2, 4..1024.
- `IDX_W`, $clog2(ENTRIES): index width (derived, not overridden).

- `CLK`  in  1  single clock, rising edge.
- `RESET`  in  1  synchronous, active-high.
- `if_pc`  in  32  fetch PC being looked up.
- `pred_taken`  out  1  prediction for `if_pc`.
- `pred_target`  out  32  predicted target; valid only when `pred_taken`=1.
- `ex_valid`  in  1  EX instruction is valid (not bubble/flushed).
- `ex_is_branch`  in  1  EX instruction is conditional branch.
- `ex_is_jump`  in  1  EX instruction is JAL/JALR.
- `ex_pc`  in  32  PC of EX instruction.
- `ex_taken`  in  1  resolved condition (1 for jumps).
- `ex_target`  in  32  computed target address.
- `ex_pred_taken`  in  1  prediction carried down pipe with the instruction.
- `ex_pred_target`  in  32  carried predicted target.
- `mispredict`  out  1  redirect fetch and flush younger stages.
- `redirect_pc`  out  32  correct next PC; meaningful when `mispredict`=1.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
- Per entry: `valid`, `tag`, `target[31:0]` (BTB), `ctr[1:0]` (BHT).
- Lookup (combinational from registered tables): `pred_taken` = valid & tag match & `ctr[1]`; `pred_target` = entry target. Forced 0 while `RESET`=1.
- Resolution (when `ex_valid` & (`ex_is_branch` | `ex_is_jump`)):
  - `actual_next` = `ex_taken` ? `ex_target` : `ex_pc`+4.
  - `pred_next` = `ex_pred_taken` ? `ex_pred_target` : `ex_pc`+4.
  - `mispredict` = (`actual_next` != `pred_next`); `redirect_pc` = `actual_next`.
  - Otherwise `mispredict`=0 and `redirect_pc`=0.
- Update at the next edge for every resolved branch or jump:
  - Counter saturates: taken increments to max 11; not-taken decrements to min 00.
  - Jumps set the counter to 11.
  - If taken, write `valid`=1, `tag`, and `target`.
  - If not taken and the tag mismatches, leave the entry untouched; no allocation on not-taken.
  - On a tag mismatch with taken, replace the entry and initialise the counter to 10 (jump: 11).
- Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup: zero-cycle (same cycle as `if_pc`).
- `mispredict`/`redirect_pc`: combinational in the EX cycle. The consumer registers the redirect at the same edge that the tables update.
- Table update becomes visible to lookups one cycle after the resolving EX cycle.
- Same-cycle read and write to the same index: lookup returns the old contents; no bypass.
- `RESET`: at the edge, all `valid`=0, all `ctr`=01, and GHR=0. During the reset cycle, `pred_taken`=0, `pred_target`=0, `mispredict`=0, and `redirect_pc`=0. Reset mid-update discards the update.
- `ex_valid`=0, or neither branch flag set: no state change.

## Configuration
- `BRANCH_PRED_GSHARE_EN` defined:
  - An `IDX_W`-bit global history register (GHR) exists.
  - BHT index = pc index XOR GHR. The BTB is still pc-indexed.
  - GHR shifts left, inserting `ex_taken` at bit 0, on each resolved conditional branch only; jumps do not shift it.
  - The GHR is non-speculative, updated from EX.
- Undefined: no GHR, and the BHT uses the plain pc index.

## Structure
- Shared package/header: counter encoding constants, default `ENTRIES`, and the `BRANCH_PRED_GSHARE_EN` guard usage.
- Sub-module `branch_target_buffer` holds the valid/tag/target arrays with lookup and write ports.
- The BHT, GHR and mispredict compare stay in `branch_predictor`.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0. Resolve a not-taken branch at 0x100 with `ex_pred_taken`=0 → `mispredict`=0; entry stays invalid.
- Taken branch at 0x100 → 0x80, predicted NT → `mispredict`=1, `redirect_pc`=0x80. The next cycle, `if_pc`=0x100 gives `pred_taken`=1 and `pred_target`=0x80.
- Saturation: four taken resolutions, then one not-taken → `ctr`=10 and the prediction stays taken. A second not-taken → `ctr`=01 and `pred_taken`=0.
- Mispredict on correct direction but wrong target: `ex_pred_taken`=1, `ex_pred_target`=0x200, `ex_taken`=1, `ex_target`=0x240 → `mispredict`=1, `redirect_pc`=0x240. The BTB target becomes 0x240.
- Alias: with `ENTRIES`=64, a taken branch at 0x100 and then one at 0x200 share an index. The 0x200 entry replaces the 0x100 entry, so a lookup of 0x100 gives `pred_taken`=0. With `ex_valid`=0 and `ex_taken`=1, nothing changes.
- Assert `RESET` in the same cycle as a taken resolution → the entry stays invalid afterwards and `mispredict`=0 in that cycle. With GSHARE: GHR=0 after reset; after branches T,T,NT, GHR=...0110.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, default depth
// and the BRANCH_PRED_GSHARE_EN build option flag.
package branch_predictor_pkg;

    localparam int unsigned BP_DEFAULT_ENTRIES = 32'd64;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

`ifdef BRANCH_PRED_GSHARE_EN
    localparam bit BP_GSHARE = 1'b1;
`else
    localparam bit BP_GSHARE = 1'b0;
`endif

    // Saturating 2-bit counter step; jumps always go straight to strong-taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                            input logic       taken,
                                            input logic       jump);
        logic [1:0] res;
        case ({jump, taken})
            2'b10, 2'b11: res = CTR_ST;
            2'b01:        res = (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
            2'b00:        res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
            default:      res = ctr;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolution signals between the pipeline and the predictor.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB: one fetch lookup port, one EX hit-check port and
// one write port. Only the valid bits are reset; tag/target are gated by valid.
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter  int unsigned ENTRIES = BP_DEFAULT_ENTRIES,
    localparam int unsigned IDX_W   = $clog2(ENTRIES),
    localparam int unsigned TAG_W   = 32'd30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [31:0]      rd_target,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic [TAG_W-1:0] ex_tag,
    output logic             ex_hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];

    // Valid bits: cleared by reset, set on allocation/refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and target storage; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
        end
    end

    // Read ports reflect the registered contents only (no write bypass).
    always_comb begin
        rd_hit    = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
        rd_target = target_r[rd_idx];
        ex_hit    = valid_r[ex_idx] && (tag_r[ex_idx] == ex_tag);
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit BHT plus tagged BTB, trained from EX.
// Define BRANCH_PRED_GSHARE_EN to index the BHT with pc index XOR global history.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_DEFAULT_ENTRIES
) (
    input logic               CLK,
    input logic               RESET,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32'd30 - IDX_W;

    logic [1:0]       bht_r [ENTRIES];
    logic [IDX_W-1:0] lu_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] lu_tag_s;
    logic [TAG_W-1:0] ex_tag_s;
    logic [IDX_W-1:0] lu_bht_idx_s;
    logic [IDX_W-1:0] ex_bht_idx_s;
    logic             lu_hit_s;
    logic [31:0]      lu_target_s;
    logic             ex_hit_s;
    logic             resolve_s;
    logic             upd_taken_s;
    logic             btb_we_s;
    logic             bht_we_s;
    logic [1:0]       bht_wdata_s;
    logic             pred_taken_s;
    logic [31:0]      pred_target_s;
    logic             mispredict_s;
    logic [31:0]      redirect_pc_s;
    logic [31:0]      actual_next_s;
    logic [31:0]      pred_next_s;

    assign lu_idx_s    = bp.if_pc[IDX_W+1:2];
    assign lu_tag_s    = bp.if_pc[31:IDX_W+2];
    assign ex_idx_s    = bp.ex_pc[IDX_W+1:2];
    assign ex_tag_s    = bp.ex_pc[31:IDX_W+2];
    assign resolve_s   = bp.ex_valid & (bp.ex_is_branch | bp.ex_is_jump);
    assign upd_taken_s = bp.ex_taken | bp.ex_is_jump;

`ifdef BRANCH_PRED_GSHARE_EN
    logic [IDX_W-1:0] ghr_r;

    // Non-speculative history: shifts only on resolved conditional branches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ghr_r <= '0;
        end else if (resolve_s && bp.ex_is_branch && !bp.ex_is_jump) begin
            ghr_r <= {ghr_r[IDX_W-2:0], bp.ex_taken};
        end
    end

    assign lu_bht_idx_s = lu_idx_s ^ ghr_r;
    assign ex_bht_idx_s = ex_idx_s ^ ghr_r;
`else
    assign lu_bht_idx_s = lu_idx_s;
    assign ex_bht_idx_s = ex_idx_s;
`endif

    branch_target_buffer #(.ENTRIES(ENTRIES)) u_btb (
        .clk       (CLK),
        .rst       (RESET),
        .rd_idx    (lu_idx_s),
        .rd_tag    (lu_tag_s),
        .rd_hit    (lu_hit_s),
        .rd_target (lu_target_s),
        .ex_idx    (ex_idx_s),
        .ex_tag    (ex_tag_s),
        .ex_hit    (ex_hit_s),
        .wr_en     (btb_we_s),
        .wr_idx    (ex_idx_s),
        .wr_tag    (ex_tag_s),
        .wr_target (bp.ex_target)
    );

    // Training decision: counters move only for BTB hits or taken allocations;
    // a not-taken miss leaves both tables untouched.
    always_comb begin
        btb_we_s    = 1'b0;
        bht_we_s    = 1'b0;
        bht_wdata_s = CTR_WNT;
        if (resolve_s) begin
            btb_we_s = upd_taken_s;
            if (ex_hit_s) begin
                bht_we_s    = 1'b1;
                bht_wdata_s = ctr_next(bht_r[ex_bht_idx_s], bp.ex_taken, bp.ex_is_jump);
            end else if (upd_taken_s) begin
                bht_we_s    = 1'b1;
                bht_wdata_s = bp.ex_is_jump ? CTR_ST : CTR_WT;
            end else begin
                bht_we_s    = 1'b0;
            end
        end else begin
            btb_we_s = 1'b0;
        end
    end

    // BHT storage; reset wins over a coincident update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bht_r <= '{default: CTR_WNT};
        end else if (bht_we_s) begin
            bht_r[ex_bht_idx_s] <= bht_wdata_s;
        end
    end

    // Zero-cycle fetch lookup, silenced during reset.
    always_comb begin
        pred_taken_s  = 1'b0;
        pred_target_s = 32'd0;
        if (RESET) begin
            pred_taken_s  = 1'b0;
            pred_target_s = 32'd0;
        end else begin
            pred_taken_s  = lu_hit_s & bht_r[lu_bht_idx_s][1];
            pred_target_s = lu_hit_s ? lu_target_s : 32'd0;
        end
    end

    // Redirect when the real next PC differs from the one fetch followed.
    always_comb begin
        actual_next_s = bp.ex_taken      ? bp.ex_target      : pc_plus4(bp.ex_pc);
        pred_next_s   = bp.ex_pred_taken ? bp.ex_pred_target : pc_plus4(bp.ex_pc);
        mispredict_s  = 1'b0;
        redirect_pc_s = 32'd0;
        if (RESET || !resolve_s) begin
            mispredict_s  = 1'b0;
            redirect_pc_s = 32'd0;
        end else begin
            mispredict_s  = (actual_next_s != pred_next_s);
            redirect_pc_s = actual_next_s;
        end
    end

    assign bp.pred_taken  = pred_taken_s;
    assign bp.pred_target = pred_target_s;
    assign bp.mispredict  = mispredict_s;
    assign bp.redirect_pc = redirect_pc_s;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic,
// checked against a table-level reference model.
module tb_branch_predictor;

    localparam int ENT = 64;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    branch_predictor_if bpif ();

    branch_predictor dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bp    (bpif)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pt;
        logic        tgt_chk;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit          m_valid [ENT];
    int unsigned m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    int unsigned m_ghr;

    function automatic int unsigned midx(logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic int unsigned mtag(logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic int unsigned bidx(logic [31:0] pc);
`ifdef BRANCH_PRED_GSHARE_EN
        return midx(pc) ^ m_ghr;
`else
        return midx(pc);
`endif
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[bidx(pc)] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tgt[i]   = 32'd0;
            m_tag[i]   = 0;
        end
        m_ghr = 0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pred_taken", 32'(bpif.pred_taken), 32'(e.pt));
            if (e.tgt_chk) check("pred_target", bpif.pred_target, e.ptgt);
            check("mispredict", 32'(bpif.mispredict), 32'(e.mp));
            check("redirect_pc", bpif.redirect_pc, e.rpc);
        end
    end

    // One cycle of stimulus: drive, push expectation, then advance the model.
    task automatic step(input bit rst, input logic [31:0] ipc,
                        input bit v, input bit br, input bit jmp,
                        input logic [31:0] epc, input bit tk, input logic [31:0] etgt,
                        input bit ptk, input logic [31:0] pt_tgt);
        exp_t        e;
        logic [31:0] actual;
        logic [31:0] pnext;
        int unsigned i;
        int unsigned b;
        @(posedge CLK);
        #1;
        RESET               = rst;
        bpif.if_pc          = ipc;
        bpif.ex_valid       = v;
        bpif.ex_is_branch   = br;
        bpif.ex_is_jump     = jmp;
        bpif.ex_pc          = epc;
        bpif.ex_taken       = tk;
        bpif.ex_target      = etgt;
        bpif.ex_pred_taken  = ptk;
        bpif.ex_pred_target = pt_tgt;

        actual = tk  ? etgt   : epc + 32'd4;
        pnext  = ptk ? pt_tgt : epc + 32'd4;
        if (rst) begin
            e = '{pt: 1'b0, tgt_chk: 1'b1, ptgt: 32'd0, mp: 1'b0, rpc: 32'd0};
        end else begin
            e.pt      = m_pred(ipc);
            e.tgt_chk = e.pt;
            e.ptgt    = m_tgt[midx(ipc)];
            if (v && (br || jmp)) begin
                e.mp  = (actual != pnext);
                e.rpc = actual;
            end else begin
                e.mp  = 1'b0;
                e.rpc = 32'd0;
            end
        end
        sb_q.push_back(e);

        if (rst) begin
            m_reset();
        end else if (v && (br || jmp)) begin
            i = midx(epc);
            b = bidx(epc);
            if (m_hit(epc)) begin
                if (jmp)      m_ctr[b] = 3;
                else if (tk)  m_ctr[b] = (m_ctr[b] + 1 > 3) ? 3 : m_ctr[b] + 1;
                else          m_ctr[b] = (m_ctr[b] - 1 < 0) ? 0 : m_ctr[b] - 1;
            end else if (tk || jmp) begin
                m_ctr[b] = jmp ? 3 : 2;
            end
            if (tk || jmp) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = mtag(epc);
                m_tgt[i]   = etgt;
            end
            if (br && !jmp) m_ghr = ((m_ghr << 1) | (tk ? 1 : 0)) % ENT;
        end
    endtask

    task automatic lookup(input logic [31:0] ipc);
        step(1'b0, ipc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic branch(input logic [31:0] ipc, input logic [31:0] epc, input bit tk,
                          input logic [31:0] etgt, input bit ptk, input logic [31:0] pt_tgt);
        step(1'b0, ipc, 1'b1, 1'b1, 1'b0, epc, tk, etgt, ptk, pt_tgt);
    endtask

    logic [31:0] pcs [8] = '{32'h100, 32'h200, 32'h104, 32'h300,
                             32'h1100, 32'h108, 32'h2104, 32'h3fc};

    initial begin
        bpif.if_pc = 32'd0;          bpif.ex_valid = 1'b0;
        bpif.ex_is_branch = 1'b0;    bpif.ex_is_jump = 1'b0;
        bpif.ex_pc = 32'd0;          bpif.ex_taken = 1'b0;
        bpif.ex_target = 32'd0;      bpif.ex_pred_taken = 1'b0;
        bpif.ex_pred_target = 32'd0;
        m_reset();

        repeat (2) step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        lookup(32'h100);
        branch(32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'd0);
        lookup(32'h100);
        branch(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        lookup(32'h100);
        repeat (4) branch(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        branch(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        lookup(32'h100);
        branch(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        lookup(32'h100);
        branch(32'h100, 32'h100, 1'b1, 32'h240, 1'b1, 32'h200);
        lookup(32'h100);
        branch(32'h100, 32'h200, 1'b1, 32'h300, 1'b0, 32'd0);
        lookup(32'h100);
        lookup(32'h200);
        step(1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'd0);
        lookup(32'h100);
        lookup(32'h200);
        step(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 32'h40, 1'b0, 32'd0);
        lookup(32'h104);
        lookup(32'h200);
        step(1'b0, 32'h400, 1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'd0);
        lookup(32'h400);
        branch(32'h104, 32'h104, 1'b1, 32'h10, 1'b0, 32'd0);
        branch(32'h108, 32'h108, 1'b1, 32'h20, 1'b0, 32'd0);
        branch(32'h104, 32'h104, 1'b0, 32'h10, 1'b1, 32'h10);
        lookup(32'h104);

        for (int n = 0; n < 800; n++) begin
            logic [31:0] ipc, epc, etgt, ptg;
            bit          rst, v, br, jmp, tk, ptk;
            int          kind;
            ipc  = pcs[$urandom_range(0, 7)];
            epc  = pcs[$urandom_range(0, 7)];
            etgt = ($urandom_range(0, 1) == 0) ? pcs[$urandom_range(0, 7)]
                                               : ($urandom() & 32'hffff_fffc);
            rst  = ($urandom_range(0, 99) == 0);
            v    = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 4);
            br   = (kind == 1) || (kind == 2) || (kind == 3);
            jmp  = (kind == 4);
            tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                ptk = m_pred(epc);
                ptg = m_tgt[midx(epc)];
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = pcs[$urandom_range(0, 7)];
            end
            step(rst, ipc, v, br, jmp, epc, tk, etgt, ptk, ptg);
        end

        repeat (2) @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
